// File: rtl/aes_rcon_gen.sv
// ============================================================================
// Module      : aes_rcon_gen
// Description : AES key-expansion round-constant generator. Produces the
//               forward (encrypt) or reverse (decrypt) rcon sequence for
//               AES-128/192/256 by GF(2^8) arithmetic (polynomial 0x11B).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_rcon_gen #(
    parameter int BYTE_POS   = 3,
    parameter bit ZERO_AFTER = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        kld,
    input  logic [1:0]  mode,
    input  logic        dir,
    input  logic        step,
    output logic [31:0] rcon,
    output logic [3:0]  rcnt,
    output logic        valid,
    output logic        last,
    output logic        done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Divide by x in GF(2^8): undo the reduction when the low bit is set
    function automatic logic [7:0] inv_xtime(input logic [7:0] b);
        if (b[0])
            inv_xtime = ((b ^ 8'h1B) >> 1) | 8'h80;
        else
            inv_xtime = b >> 1;
    endfunction

    // Number of round constants consumed by each key size
    function automatic logic [3:0] seq_len(input logic [1:0] m);
        case (m)
            2'b01:   seq_len = 4'd8;
            2'b10:   seq_len = 4'd7;
            default: seq_len = 4'd10;
        endcase
    endfunction

    // Final forward constant of an n-long sequence: x^(n-1), computed rather
    // than looked up so the reverse start stays consistent with xtime.
    function automatic logic [7:0] final_const(input logic [3:0] n);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 9; i++) begin
            if (i < int'(n) - 1)
                r = xtime(r);
        end
        final_const = r;
    endfunction

    logic [1:0] state;
    logic [1:0] mode_q;
    logic       dir_q;
    logic [7:0] rc;
    logic [3:0] cnt;

    logic [1:0] mode_eff;
    logic [7:0] first_rc;
    logic [3:0] n_act;
    logic       is_last;
    logic [7:0] rc_out;

    // Start-of-sequence decode from the live inputs, used only on kld;
    // reserved mode 11 collapses onto AES-128.
    always_comb begin
        mode_eff = (mode == 2'b11) ? 2'b00 : mode;
        first_rc = dir ? final_const(seq_len(mode_eff)) : 8'h01;
    end

    // Position within the latched sequence
    always_comb begin
        n_act   = seq_len(mode_q);
        is_last = (state == S_RUN) && (cnt == n_act - 4'd1);
    end

    // Sequence state: kld restarts from any state and beats a same-cycle step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            mode_q <= 2'b00;
            dir_q  <= 1'b0;
            rc     <= 8'h00;
            cnt    <= 4'd0;
        end else if (kld) begin
            state  <= S_RUN;
            mode_q <= mode_eff;
            dir_q  <= dir;
            rc     <= first_rc;
            cnt    <= 4'd0;
        end else if (step && (state == S_RUN)) begin
            if (is_last) begin
                state <= S_DONE;
            end else begin
                cnt <= cnt + 4'd1;
                rc  <= dir_q ? inv_xtime(rc) : xtime(rc);
            end
        end
    end

    // Output decode; the last constant is either kept or blanked in DONE
    always_comb begin
        case (state)
            S_RUN:   rc_out = rc;
            S_DONE:  rc_out = ZERO_AFTER ? 8'h00 : rc;
            default: rc_out = 8'h00;
        endcase
        rcon  = {24'h000000, rc_out} << (8 * BYTE_POS);
        rcnt  = cnt;
        valid = (state == S_RUN);
        last  = is_last;
        done  = (state == S_DONE);
    end

endmodule

`default_nettype wire

// File: tb/tb_aes_rcon_gen.sv
// ============================================================================
// Module      : tb_aes_rcon_gen
// Description : Self-checking bench for aes_rcon_gen. Instance a uses the
//               default byte position with zero-after-done; instance b puts
//               the constant in bits 7:0 and holds it in DONE.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_rcon_gen;

    typedef struct {
        logic       kld;
        logic [1:0] mode;
        logic       dir;
        logic       step;
        logic [7:0] rc;
        logic [3:0] cnt;
        logic       v;
        logic       l;
        logic       d;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        kld;
    logic [1:0]  mode;
    logic        dir;
    logic        step;
    logic [31:0] rcon_a, rcon_b;
    logic [3:0]  rcnt_a, rcnt_b;
    logic        valid_a, valid_b, last_a, last_b, done_a, done_b;

    int tests;
    int fails;
    vec_t vecs[$];

    aes_rcon_gen #(.BYTE_POS(3), .ZERO_AFTER(1'b1)) u_a (
        .clk(clk), .rst(rst), .kld(kld), .mode(mode), .dir(dir), .step(step),
        .rcon(rcon_a), .rcnt(rcnt_a), .valid(valid_a), .last(last_a), .done(done_a)
    );

    aes_rcon_gen #(.BYTE_POS(0), .ZERO_AFTER(1'b0)) u_b (
        .clk(clk), .rst(rst), .kld(kld), .mode(mode), .dir(dir), .step(step),
        .rcon(rcon_b), .rcnt(rcnt_b), .valid(valid_b), .last(last_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic k, input logic [1:0] m, input logic dr, input logic s,
                       input logic [7:0] rc, input logic [3:0] c,
                       input logic v, input logic l, input logic d);
        vec_t e;
        e.kld = k; e.mode = m; e.dir = dr; e.step = s;
        e.rc = rc; e.cnt = c; e.v = v; e.l = l; e.d = d;
        vecs.push_back(e);
    endtask

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic k, input logic [1:0] m, input logic dr, input logic s);
        kld = k; mode = m; dir = dr; step = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] f10[10];
        logic [7:0] f8[8];
        logic [7:0] r7[7];
        logic [7:0] hold_b;
        logic [7:0] exp_b;

        f10 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
        f8  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        r7  = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

        // AES-128 forward, then exhaust and poke DONE
        add(1, 2'b00, 0, 0, f10[0], 0, 1, 0, 0);
        for (int i = 1; i < 10; i++) add(0, 2'b00, 0, 1, f10[i], 4'(i), 1, (i == 9), 0);
        add(0, 2'b00, 0, 1, 8'h00, 9, 0, 0, 1);
        add(0, 2'b00, 0, 1, 8'h00, 9, 0, 0, 1);
        // AES-256 reverse
        add(1, 2'b10, 1, 0, r7[0], 0, 1, 0, 0);
        for (int i = 1; i < 7; i++) add(0, 2'b10, 1, 1, r7[i], 4'(i), 1, (i == 6), 0);
        add(0, 2'b10, 1, 1, 8'h00, 6, 0, 0, 1);
        // AES-192 forward; step in DONE with changed mode/dir is ignored
        add(1, 2'b01, 0, 0, f8[0], 0, 1, 0, 0);
        for (int i = 1; i < 8; i++) add(0, 2'b01, 0, 1, f8[i], 4'(i), 1, (i == 7), 0);
        add(0, 2'b01, 0, 1, 8'h00, 7, 0, 0, 1);
        add(0, 2'b10, 1, 1, 8'h00, 7, 0, 0, 1);
        // Reserved mode behaves as AES-128; mode/dir wiggle in RUN has no effect
        add(1, 2'b11, 0, 0, f10[0], 0, 1, 0, 0);
        for (int i = 1; i < 5; i++) add(0, 2'b10, 1, 1, f10[i], 4'(i), 1, 0, 0);
        // kld with step at rcnt 4 restarts cleanly
        add(1, 2'b00, 0, 1, 8'h01, 0, 1, 0, 0);
        add(0, 2'b00, 0, 1, 8'h02, 1, 1, 0, 0);
        // Reverse AES-128 start and the 0x36 -> 0x1B -> ... -> 0x80 wrap
        add(1, 2'b00, 1, 0, 8'h36, 0, 1, 0, 0);
        add(0, 2'b00, 1, 1, 8'h1B, 1, 1, 0, 0);
        add(0, 2'b00, 1, 1, 8'h80, 2, 1, 0, 0);

        tests = 0;
        fails = 0;
        rst = 1'b1; kld = 1'b0; mode = 2'b00; dir = 1'b0; step = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_a", {rcon_a, rcnt_a, valid_a, last_a, done_a, 1'b0}, 40'h0);
        check("reset_b", {rcon_b, rcnt_b, valid_b, last_b, done_b, 1'b0}, 40'h0);
        rst = 1'b0;
        drive(0, 2'b00, 0, 1);
        check("idle_step", {rcon_a, rcnt_a, valid_a, last_a, done_a, 1'b0}, 40'h0);

        hold_b = 8'h00;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].kld, vecs[i].mode, vecs[i].dir, vecs[i].step);
            check($sformatf("vec%0d_a", i),
                  {rcon_a, rcnt_a, valid_a, last_a, done_a, 1'b0},
                  {vecs[i].rc, 24'h000000, vecs[i].cnt, vecs[i].v, vecs[i].l, vecs[i].d, 1'b0});
            if (vecs[i].v) hold_b = vecs[i].rc;
            exp_b = vecs[i].d ? hold_b : vecs[i].rc;
            check($sformatf("vec%0d_b", i),
                  {rcon_b, rcnt_b, valid_b, last_b, done_b, 1'b0},
                  {24'h000000, exp_b, vecs[i].cnt, vecs[i].v, vecs[i].l, vecs[i].d, 1'b0});
        end

        // Asynchronous reset at rcnt 5, observed before any clock edge
        drive(1, 2'b00, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 2'b00, 0, 1);
        check("pre_rst", {rcon_a, rcnt_a, valid_a, last_a, done_a, 1'b0},
              {8'h20, 24'h0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0});
        step = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_a", {rcon_a, rcnt_a, valid_a, last_a, done_a, 1'b0}, 40'h0);
        check("async_rst_b", {rcon_b, rcnt_b, valid_b, last_b, done_b, 1'b0}, 40'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 2'b00, 0, 1);
        drive(0, 2'b00, 0, 1);
        check("post_rst_step", {rcon_a, rcnt_a, valid_a, last_a, done_a, 1'b0}, 40'h0);
        drive(1, 2'b01, 1, 0);
        check("post_rst_kld", {rcon_a, rcnt_a, valid_a, last_a, done_a, 1'b0},
              {8'h80, 24'h0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/aes_rcon_gen.md
AES_RCON_GEN -- requirements
Module: aes_rcon_gen

Interface
REQ-001 Parameter BYTE_POS, default 3, selects which byte of the 32-bit rcon word carries the constant (3 = bits 31:24); all other bytes SHALL be zero.
REQ-002 Parameter ZERO_AFTER, default 1: when 1, rcon SHALL be zero in DONE; when 0, rcon SHALL hold its last value.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 kld  input  1  load/start; restarts the sequence.
REQ-006 mode  input  2  key size, sampled on kld: 00 = AES-128, 01 = AES-192, 10 = AES-256, 11 = reserved, treated as 00.
REQ-007 dir  input  1  direction, sampled on kld: 0 = forward (encrypt schedule), 1 = reverse (decrypt schedule).
REQ-008 step  input  1  advance to the next round constant.
REQ-009 rcon  output  32  current round-constant word.
REQ-010 rcnt  output  4  index of the current constant, 0..N-1.
REQ-011 valid  output  1  rcon holds a constant of the active sequence.
REQ-012 last  output  1  current constant is the final one of the sequence.
REQ-013 done  output  1  sequence exhausted.

Function
REQ-014 The block SHALL have the states IDLE, RUN and DONE. The sequence length N SHALL be 10 for mode 00/11, 8 for mode 01 and 7 for mode 10.
REQ-015 Generation:
- Constants SHALL be computed arithmetically in GF(2^8) with polynomial 0x11B.
- A constant table SHALL NOT be used.
REQ-016 On kld, in any state, the block SHALL:
- latch mode and dir;
- set rcnt = 0, valid = 1, done = 0;
- enter RUN.
REQ-017 The first constant after kld SHALL be:
- 0x01 when forward;
- the final forward constant when reverse: 0x36 (N=10), 0x80 (N=8) or 0x40 (N=7).
REQ-018 Forward step (xtime):
- rc_next = (rc << 1) & 0xFF;
- then XOR with 0x1B if rc[7] was 1.
REQ-019 Reverse step (inverse xtime):
- if rc[0] = 1: rc_next = ((rc ^ 0x1B) >> 1) | 0x80;
- else: rc_next = rc >> 1.
REQ-020 On step in RUN with last = 0, the block SHALL increment rcnt and update rcon to rc_next on the same clock edge, so outputs change one cycle after the sampled step.
REQ-021 last SHALL be 1 exactly when the state is RUN and rcnt = N-1.
REQ-022 On step in RUN with last = 1, the block SHALL:
- enter DONE;
- set valid = 0, last = 0, done = 1;
- apply REQ-002 to rcon;
- hold rcnt at N-1.
REQ-023 step in IDLE or DONE SHALL be ignored, with no output change.
REQ-024 kld and step asserted in the same cycle: kld SHALL take priority and step is discarded.
REQ-025 Changes on mode or dir while in RUN or DONE SHALL have no effect until the next kld.
REQ-026 A constant SHALL never be 0x00 while valid = 1, and rcnt SHALL never exceed N-1.

Reset
REQ-027 While rst = 1, asynchronously, the block SHALL:
- set rcon = 0, rcnt = 0, valid = 0, last = 0, done = 0;
- enter IDLE.
REQ-028 Reset mid-sequence SHALL abandon the sequence; the block SHALL remain in IDLE until kld after rst is released.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- mode 00, dir 0, kld then 10 steps -> rcon[31:24] = 01,02,04,08,10,20,40,80,1B,36; last on rcnt 9; then done = 1, rcon = 0.
- mode 10, dir 1, kld then steps -> 40,20,10,08,04,02,01; last at rcnt 6; next step gives done = 1.
- mode 01, dir 0 -> 01..80 over 8 constants; step in DONE leaves all outputs unchanged.
- kld asserted together with step at rcnt 4 -> next cycle rcnt = 0, rcon = 0x01000000, valid = 1.
- rst asserted at rcnt 5 -> all outputs 0 immediately, without waiting for a clock edge; step after release is ignored until kld.
- mode 11 -> identical to mode 00; with BYTE_POS = 0 -> constant in bits 7:0 (0x00000001 first).
